// File: rtl/nec_ir_transmitter.sv
// NEC infrared frame / repeat-code transmitter with a Wishbone register interface.
// Produces leader, 32 LSB-first data bits and stop burst, optionally carrier-modulated.
module nec_ir_transmitter #(
    parameter int PSIZE = 20,
    parameter int CSIZE = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [31:0] wbs_adr_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        ir_out,
    output logic        irq
);
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
    localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
    localparam logic [2:0] ST_BIT_MARK   = 3'd3;
    localparam logic [2:0] ST_BIT_SPACE  = 3'd4;
    localparam logic [2:0] ST_STOP_MARK  = 3'd5;
    localparam logic [2:0] ST_REP_MARK   = 3'd6;
    localparam logic [2:0] ST_REP_SPACE  = 3'd7;

    localparam logic [PSIZE-1:0] P_ONE = PSIZE'(1);
    localparam logic [CSIZE-1:0] C_ONE = CSIZE'(1);

    function automatic logic is_mark_f(input logic [2:0] s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) ||
               (s == ST_STOP_MARK) || (s == ST_REP_MARK);
    endfunction

    logic [31:0] lane_mask;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    logic req, wr, wr_ctrl, wr_data, wr_unit, wr_carrier;
    logic unused_adr;

    assign req        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr         = req & wbs_we_i;
    assign wr_ctrl    = wr & (wbs_adr_i[3:2] == 2'd0);
    assign wr_data    = wr & (wbs_adr_i[3:2] == 2'd1);
    assign wr_unit    = wr & (wbs_adr_i[3:2] == 2'd2);
    assign wr_carrier = wr & (wbs_adr_i[3:2] == 2'd3);
    assign unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    logic             enable_reg, carrier_en_reg, invert_reg, irq_en_reg, done_reg;
    logic [31:0]      data_reg;
    logic [PSIZE-1:0] unit_reg;
    logic [CSIZE-1:0] carrier_reg;

    logic [2:0]       state_reg, state_next;
    logic [31:0]      shift_reg;
    logic [PSIZE-1:0] unit_lat, tick_cnt;
    logic [CSIZE-1:0] carrier_lat, car_cnt;
    logic [4:0]       units_left, dur_next, bit_cnt;
    logic             phase_reg;

    logic busy, tick, leave, abort, frame_end, enable_new, start_go, done_clr, burst;
    logic [31:0] ctrl_word, rdata;

    assign busy       = (state_reg != ST_IDLE);
    assign tick       = (tick_cnt == '0);
    assign leave      = tick && (units_left == 5'd1);
    assign abort      = busy && !enable_reg;
    assign frame_end  = leave && (state_reg == ST_STOP_MARK) && !abort;
    // A write that sets enable together with start must launch the frame.
    assign enable_new = (wr_ctrl && wbs_sel_i[0]) ? wbs_dat_i[0] : enable_reg;
    assign start_go   = wr_ctrl && wbs_sel_i[1] && (wbs_dat_i[8] || wbs_dat_i[9]) &&
                        enable_new && !busy;
    assign done_clr   = wr_ctrl && wbs_sel_i[2] && wbs_dat_i[17];
    assign irq        = done_reg & irq_en_reg;
    assign burst      = is_mark_f(state_reg) & (carrier_en_reg ? phase_reg : 1'b1);

    assign ctrl_word = {14'd0, done_reg, busy, 8'd0, 4'd0,
                        irq_en_reg, invert_reg, carrier_en_reg, enable_reg};

    always_comb begin
        rdata = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0:    rdata = ctrl_word;
            2'd1:    rdata = data_reg;
            2'd2:    rdata = 32'(unit_reg);
            default: rdata = 32'(carrier_reg);
        endcase
    end

    always_comb begin
        state_next = state_reg;
        dur_next   = 5'd0;
        if (leave) begin
            case (state_reg)
                ST_LEAD_MARK:  begin state_next = ST_LEAD_SPACE; dur_next = 5'd8; end
                ST_LEAD_SPACE: begin state_next = ST_BIT_MARK;   dur_next = 5'd1; end
                ST_BIT_MARK:   begin
                    state_next = ST_BIT_SPACE;
                    dur_next   = shift_reg[0] ? 5'd3 : 5'd1;
                end
                ST_BIT_SPACE:  begin
                    state_next = (bit_cnt == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                    dur_next   = 5'd1;
                end
                ST_REP_MARK:   begin state_next = ST_REP_SPACE;  dur_next = 5'd4; end
                ST_REP_SPACE:  begin state_next = ST_STOP_MARK;  dur_next = 5'd1; end
                default:       begin state_next = ST_IDLE;       dur_next = 5'd0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= 32'd0;
            enable_reg     <= 1'b0;
            carrier_en_reg <= 1'b0;
            invert_reg     <= 1'b0;
            irq_en_reg     <= 1'b0;
            done_reg       <= 1'b0;
            data_reg       <= 32'd0;
            unit_reg       <= '0;
            carrier_reg    <= '0;
        end else begin
            wbs_ack_o <= req;
            if (req) wbs_dat_o <= rdata;
            if (wr_ctrl && wbs_sel_i[0]) begin
                enable_reg     <= wbs_dat_i[0];
                carrier_en_reg <= wbs_dat_i[1];
                invert_reg     <= wbs_dat_i[2];
                irq_en_reg     <= wbs_dat_i[3];
            end
            if (wr_data)
                data_reg <= (data_reg & ~lane_mask) | (wbs_dat_i & lane_mask);
            if (wr_unit)
                unit_reg <= (unit_reg & ~lane_mask[PSIZE-1:0]) |
                            (wbs_dat_i[PSIZE-1:0] & lane_mask[PSIZE-1:0]);
            if (wr_carrier)
                carrier_reg <= (carrier_reg & ~lane_mask[CSIZE-1:0]) |
                               (wbs_dat_i[CSIZE-1:0] & lane_mask[CSIZE-1:0]);
            // Completion beats a simultaneous write-one-to-clear.
            if (frame_end)     done_reg <= 1'b1;
            else if (done_clr) done_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= 32'd0;
            unit_lat    <= '0;
            tick_cnt    <= '0;
            carrier_lat <= '0;
            car_cnt     <= '0;
            units_left  <= 5'd0;
            bit_cnt     <= 5'd0;
            phase_reg   <= 1'b0;
        end else if (abort) begin
            state_reg <= ST_IDLE;
        end else if (start_go) begin
            state_reg   <= wbs_dat_i[8] ? ST_LEAD_MARK : ST_REP_MARK;
            shift_reg   <= data_reg;
            unit_lat    <= unit_reg;
            tick_cnt    <= unit_reg;
            carrier_lat <= carrier_reg;
            car_cnt     <= carrier_reg;
            units_left  <= 5'd16;
            bit_cnt     <= 5'd0;
            phase_reg   <= 1'b1;
        end else if (busy) begin
            state_reg <= state_next;
            if (tick) begin
                tick_cnt   <= unit_lat;
                units_left <= leave ? dur_next : units_left - 5'd1;
            end else begin
                tick_cnt <= tick_cnt - P_ONE;
            end
            if (leave && (state_reg == ST_BIT_SPACE)) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + 5'd1;
            end
            // Every mark starts its carrier at the high phase.
            if (leave && is_mark_f(state_next)) begin
                phase_reg <= 1'b1;
                car_cnt   <= carrier_lat;
            end else if (is_mark_f(state_reg)) begin
                if (car_cnt == '0) begin
                    phase_reg <= ~phase_reg;
                    car_cnt   <= carrier_lat;
                end else begin
                    car_cnt <= car_cnt - C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ir_out <= 1'b0;
        else        ir_out <= burst ^ invert_reg;
    end

endmodule
